// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the
// parametrised register file.
package regfile_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_CLEARING
   } clr_st_e;

   localparam int RD_COMB = 0;
   localparam int RD_REGD = 1;

   function automatic int depth_f(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/regfile_param_if.sv
// regfile_param_if: port bundle between datapath
// and the register file.
interface regfile_param_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
);
   logic              WE3;
   logic [ADDR_W-1:0] A1;
   logic [ADDR_W-1:0] A2;
   logic [ADDR_W-1:0] A3;
   logic [XLEN-1:0]   WD3;
   logic              CLR;
   logic [XLEN-1:0]   RD1;
   logic [XLEN-1:0]   RD2;
   logic              BUSY;

   modport master (
      output WE3, A1, A2, A3, WD3, CLR,
      input  RD1, RD2, BUSY
   );

   modport slave (
      input  WE3, A1, A2, A3, WD3, CLR,
      output RD1, RD2, BUSY
   );
endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port with zero-entry
// mux, write/clear bypass and optional out reg.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int RD_REG   = RD_COMB
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]   mem_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [XLEN-1:0]   wr_data_i,
   input  logic              clr_en_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   output logic [XLEN-1:0]   rd_o
);

   logic            zero_hit;
   logic [XLEN-1:0] rd_d;

   assign zero_hit = (ZERO_REG != 0) &&
                     (addr_i == '0);

   // value the entry holds after this edge
   always_comb begin
      rd_d = mem_i;
      if (zero_hit)
         rd_d = '0;
      else if (wr_en_i &&
               (wr_addr_i == addr_i))
         rd_d = wr_data_i;
      else if (clr_en_i &&
               (clr_addr_i == addr_i))
         rd_d = '0;
   end

   generate
      if (RD_REG == RD_REGD) begin : g_reg
         logic [XLEN-1:0] rd_q;

         // registered read with bypass
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
               rd_q <= '0;
            else
               rd_q <= rd_d;
         end

         assign rd_o = rd_q;
      end else begin : g_comb
         logic unused_byp;

         assign rd_o = zero_hit ? '0 : mem_i;
         assign unused_byp = ^{clk_i, rst_ni, rd_d};
      end
   endgenerate

endmodule

// File: rtl/regfile_param.sv
// regfile_param: 2R1W register file with array
// reset and a one-entry-per-cycle clear engine.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int RD_REG   = RD_COMB
) (
   input logic      CLK,
   input logic      RST_N,
   regfile_param_if.slave bus
);

   localparam int DEPTH = depth_f(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST =
      ADDR_W'(DEPTH - 1);

   logic [XLEN-1:0]   mem_q [DEPTH];
   clr_st_e           state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy;
   logic              wr_en;
   logic              a3_zero;

   assign busy    = (state_q == ST_CLEARING);
   assign a3_zero = (ZERO_REG != 0) &&
                    (bus.A3 == '0);
   assign wr_en   = bus.WE3 && !busy && !a3_zero;
   assign bus.BUSY = busy;

   // clear FSM next state and pointer
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.CLR) begin
               state_d = ST_CLEARING;
               ptr_d   = '0;
            end
         end
         ST_CLEARING: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // clear FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // array: reset, clear engine, then writes
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (busy) begin
         mem_q[ptr_q] <= '0;
      end else if (wr_en) begin
         mem_q[bus.A3] <= bus.WD3;
      end
   end

   regfile_rd_port #(
      .XLEN     (XLEN),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .RD_REG   (RD_REG)
   ) u_rd1 (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .addr_i     (bus.A1),
      .mem_i      (mem_q[bus.A1]),
      .wr_en_i    (wr_en),
      .wr_addr_i  (bus.A3),
      .wr_data_i  (bus.WD3),
      .clr_en_i   (busy),
      .clr_addr_i (ptr_q),
      .rd_o       (bus.RD1)
   );

   regfile_rd_port #(
      .XLEN     (XLEN),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .RD_REG   (RD_REG)
   ) u_rd2 (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .addr_i     (bus.A2),
      .mem_i      (mem_q[bus.A2]),
      .wr_en_i    (wr_en),
      .wr_addr_i  (bus.A3),
      .wr_data_i  (bus.WD3),
      .clr_en_i   (busy),
      .clr_addr_i (ptr_q),
      .rd_o       (bus.RD2)
   );

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench over four
// configurations of regfile_param.
module tb_regfile_param;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   regfile_param_if #(.XLEN(32), .ADDR_W(5)) if0 ();
   regfile_param_if #(.XLEN(32), .ADDR_W(5)) if1 ();
   regfile_param_if #(.XLEN(32), .ADDR_W(5)) if2 ();
   regfile_param_if #(.XLEN(8),  .ADDR_W(3)) if3 ();

   regfile_param #(
      .XLEN(32), .ADDR_W(5), .ZERO_REG(1), .RD_REG(0)
   ) u0 (.CLK(clk), .RST_N(rst_n), .bus(if0));

   regfile_param #(
      .XLEN(32), .ADDR_W(5), .ZERO_REG(0), .RD_REG(0)
   ) u1 (.CLK(clk), .RST_N(rst_n), .bus(if1));

   regfile_param #(
      .XLEN(32), .ADDR_W(5), .ZERO_REG(1), .RD_REG(1)
   ) u2 (.CLK(clk), .RST_N(rst_n), .bus(if2));

   regfile_param #(
      .XLEN(8), .ADDR_W(3), .ZERO_REG(1), .RD_REG(0)
   ) u3 (.CLK(clk), .RST_N(rst_n), .bus(if3));

   localparam int S0R1 = 0;
   localparam int S0R2 = 1;
   localparam int S0B  = 2;
   localparam int S1R1 = 3;
   localparam int S2R1 = 4;
   localparam int S2R2 = 5;
   localparam int S3R1 = 6;
   localparam int S3B  = 7;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sbq[$];
   int total = 0;
   int bad   = 0;

   function automatic logic [31:0] act(input int sel);
      case (sel)
         S0R1:    return if0.RD1;
         S0R2:    return if0.RD2;
         S0B:     return {31'b0, if0.BUSY};
         S1R1:    return if1.RD1;
         S2R1:    return if2.RD1;
         S2R2:    return if2.RD2;
         S3R1:    return {24'b0, if3.RD1};
         S3B:     return {31'b0, if3.BUSY};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic push(input string nm,
                       input int sel,
                       input logic [31:0] exp);
      sb_item_t it;
      it.name = nm;
      it.sel  = sel;
      it.exp  = exp;
      sbq.push_back(it);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // monitor: compare queued expectations mid-cycle
   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         sb_item_t it;
         logic [31:0] a;
         it = sbq.pop_front();
         a  = act(it.sel);
         total++;
         if (a !== it.exp) begin
            bad++;
            $display("FAIL %s: got %h want %h",
                     it.name, a, it.exp);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] wide;
      rst_n = 1'b0;
      if0.WE3 = 0; if0.A1 = 0; if0.A2 = 0;
      if0.A3 = 0; if0.WD3 = 0; if0.CLR = 0;
      if1.WE3 = 0; if1.A1 = 0; if1.A2 = 0;
      if1.A3 = 0; if1.WD3 = 0; if1.CLR = 0;
      if2.WE3 = 0; if2.A1 = 0; if2.A2 = 0;
      if2.A3 = 0; if2.WD3 = 0; if2.CLR = 0;
      if3.WE3 = 0; if3.A1 = 0; if3.A2 = 0;
      if3.A3 = 0; if3.WD3 = 0; if3.CLR = 0;
      step();
      step();
      rst_n = 1'b1;
      push("rst_u0_rd1", S0R1, 0);
      push("rst_u0_busy", S0B, 0);
      push("rst_u1_rd1", S1R1, 0);
      push("rst_u2_rd1", S2R1, 0);
      push("rst_u3_busy", S3B, 0);
      step();

      // defaults, combinational reads
      if0.WE3 = 1; if0.A3 = 0; if0.WD3 = 30;
      step();
      if0.A3 = 21; if0.WD3 = 1337;
      step();
      if0.A3 = 10; if0.WD3 = 228;
      step();
      if0.WE3 = 0;
      if0.A1 = 21; if0.A2 = 10;
      push("u0_rd1_a21", S0R1, 1337);
      push("u0_rd2_a10", S0R2, 228);
      step();
      if0.A1 = 0;
      push("u0_zero_reg", S0R1, 0);
      step();
      if0.WE3 = 1; if0.A3 = 7; if0.WD3 = 77;
      if0.A1 = 7;
      push("u0_no_bypass", S0R1, 0);
      step();
      if0.WE3 = 0;
      push("u0_after_edge", S0R1, 77);
      step();

      // ZERO_REG=0: entry 0 is storage
      if1.WE3 = 1; if1.A3 = 0;
      if1.WD3 = 32'hDEAD_BEEF; if1.A1 = 0;
      step();
      if1.WE3 = 0;
      push("u1_entry0", S1R1, 32'hDEAD_BEEF);
      step();

      // RD_REG=1: bypass and latency
      if2.WE3 = 1; if2.A3 = 6; if2.WD3 = 7;
      step();
      if2.A3 = 5; if2.WD3 = 32'h55;
      if2.A1 = 5; if2.A2 = 6;
      step();
      if2.WE3 = 0;
      push("u2_bypass", S2R1, 32'h55);
      push("u2_old_val", S2R2, 7);
      step();
      if2.A1 = 6;
      push("u2_latency", S2R1, 32'h55);
      step();
      push("u2_rd_new", S2R1, 7);
      if2.WE3 = 1; if2.A3 = 0; if2.WD3 = 1;
      if2.A2 = 0;
      step();
      if2.WE3 = 0;
      push("u2_zero_reg", S2R2, 0);
      step();

      // clear engine on defaults
      for (int i = 1; i < 32; i++) begin
         if0.WE3 = 1; if0.A3 = 5'(i);
         if0.WD3 = i;
         step();
      end
      if0.WE3 = 0;
      if0.A1 = 31; if0.A2 = 3;
      push("u0_fill31", S0R1, 31);
      push("u0_fill3", S0R2, 3);
      step();
      if0.CLR = 1;
      step();
      if0.CLR = 0;
      for (int k = 0; k < 32; k++) begin
         if (k == 31) begin
            if0.WE3 = 1; if0.A3 = 3;
            if0.WD3 = 99;
         end
         if (k == 4) begin
            push("u0_part_hi", S0R1, 31);
            push("u0_part_lo", S0R2, 0);
         end
         push("u0_busy_hi", S0B, 1);
         step();
      end
      if0.WE3 = 0;
      push("u0_busy_lo", S0B, 0);
      for (int a = 0; a < 32; a++) begin
         if0.A1 = 5'(a);
         if0.A2 = 5'(31 - a);
         push("u0_clr_rd1", S0R1, 0);
         push("u0_clr_rd2", S0R2, 0);
         step();
      end
      if0.WE3 = 1; if0.A3 = 9; if0.WD3 = 32'h99;
      if0.A1 = 9;
      step();
      if0.WE3 = 0;
      push("u0_post_clr_wr", S0R1, 32'h99);
      step();

      // XLEN=8, ADDR_W=3
      wide = 32'h1FF;
      if3.WE3 = 1; if3.A3 = 7; if3.WD3 = wide[7:0];
      step();
      if3.WE3 = 0; if3.A1 = 7;
      push("u3_trunc", S3R1, 32'hFF);
      if3.CLR = 1;
      step();
      if3.CLR = 0;
      for (int k = 0; k < 8; k++) begin
         push("u3_busy_hi", S3B, 1);
         step();
      end
      push("u3_busy_lo", S3B, 0);
      push("u3_cleared", S3R1, 0);
      step();

      // reset in the middle of a clear
      if0.WE3 = 1; if0.A3 = 12; if0.WD3 = 12;
      step();
      if0.WE3 = 0; if0.A1 = 12;
      push("u0_pre_rst", S0R1, 12);
      if0.CLR = 1;
      step();
      if0.CLR = 0;
      for (int k = 0; k < 10; k++) step();
      push("u0_mid_busy", S0B, 1);
      push("u0_mid_e12", S0R1, 12);
      step();
      rst_n = 1'b0;
      #1;
      push("u0_rst_busy", S0B, 0);
      push("u0_rst_e12", S0R1, 0);
      push("u2_rst_rd1", S2R1, 0);
      step();
      rst_n = 1'b1;
      if0.WE3 = 1; if0.A3 = 4; if0.WD3 = 44;
      if0.A1 = 4;
      push("u0_rel_pre", S0R1, 0);
      step();
      if0.WE3 = 0;
      push("u0_rel_wr", S0R1, 44);
      push("u0_rel_busy", S0B, 0);
      step();
      step();

      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d want 0",
                  sbq.size());
      end
      $display("test done: total=%0d bad=%0d",
               total, bad);
      $finish;
   end

endmodule
